fetch_stage: RTL and testbench

- Instruction-fetch stage and F/D pipeline register directly upstream of the opcode decoder.
- Holds the PC and drives the instruction-memory address; latches the returned word into the F/D register.
- Presents fd_opcode (instruction bits [31:27]) to the decoder. A flushed or invalid slot reads as all-zero, which the decoder treats as an R-type nop.
- Honours stall and redirect requests from later stages, and keeps a saturating stall-cycle counter for debug.

---
 rtl/fetch_stage.sv | 75 +++++++
 tb/tb_fetch_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, imem addressing and F/D register.
// Handles redirect flushes, stalls and a saturating stall-cycle counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          IMEM_AW  = 12,
  parameter int          CNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_q,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        pc,
  output logic [31:0]        fd_insn,
  output logic [31:0]        fd_pc_plus1,
  output logic               fd_valid,
  output logic [4:0]         fd_opcode,
  output logic [CNT_W-1:0]   stall_count
);

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pcPlus1;
    logic        valid;
  } fdReg_t;

  fdReg_t      fdReg;
  logic [31:0] pcPlus1;
  logic        cntSat;

  assign pcPlus1   = pc + 32'd1;
  assign cntSat    = &stall_count;
  assign imem_addr = pc[IMEM_AW-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      pc    <= RESET_PC;
      fdReg <= '0;
    end else begin
      priority case (1'b1)
        redirect: begin
          pc    <= redirect_pc;
          fdReg <= '0;
        end
        stall: begin
          pc    <= pc;
          fdReg <= fdReg;
        end
        default: begin
          pc            <= pcPlus1;
          fdReg.insn    <= imem_q;
          fdReg.pcPlus1 <= pcPlus1;
          fdReg.valid   <= 1'b1;
        end
      endcase
    end
  end

  // Counts only true stalls; a redirect in the same cycle wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && !redirect && !cntSat) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign fd_insn     = fdReg.insn;
  assign fd_pc_plus1 = fdReg.pcPlus1;
  assign fd_valid    = fdReg.valid;
  assign fd_opcode   = fdReg.valid ? fdReg.insn[31:27] : 5'd0;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a transaction-level model.
// Directed scenarios followed by randomized stall/redirect/reset traffic.
module tb_fetch_stage;

  localparam int AW = 12;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_q;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic [31:0]   pc;
  logic [31:0]   fd_insn;
  logic [31:0]   fd_pc_plus1;
  logic          fd_valid;
  logic [4:0]    fd_opcode;
  logic [CW-1:0] stall_count;

  logic [31:0] mem [1 << AW];

  int tests = 0;
  int fails = 0;

  bit [31:0] mPc;
  bit [31:0] mInsn;
  bit [31:0] mPp1;
  bit        mValid;
  int        mCnt;

  fetch_stage #(
    .RESET_PC(32'd0),
    .IMEM_AW (AW),
    .CNT_W   (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_q     (imem_q),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc         (pc),
    .fd_insn    (fd_insn),
    .fd_pc_plus1(fd_pc_plus1),
    .fd_valid   (fd_valid),
    .fd_opcode  (fd_opcode),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  assign imem_q = mem[imem_addr];

  task automatic fillPattern();
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 | i;
  endtask

  // One clock edge with the given controls; model follows the rules.
  task automatic cycle(input bit r, input bit s, input bit d,
                       input logic [31:0] t);
    bit [31:0] word;
    reset = r; stall = s; redirect = d; redirect_pc = t;
    word = mem[mPc % (1 << AW)];
    @(posedge clock);
    if (r) begin
      mPc = 0; mInsn = 0; mPp1 = 0; mValid = 0; mCnt = 0;
    end else if (d) begin
      mPc = t; mInsn = 0; mPp1 = 0; mValid = 0;
    end else if (s) begin
      mCnt = (mCnt >= CMAX) ? CMAX : mCnt + 1;
    end else begin
      mInsn = word; mPp1 = mPc + 1; mValid = 1; mPc = mPc + 1;
    end
    #1;
    reset = 0; stall = 0; redirect = 0;
  endtask

  task automatic test_reset();
    fillPattern();
    cycle(1, 0, 0, 0);
    tests++;
    if (pc !== 32'd0) begin
      fails++; $display("FAIL reset_pc got %h exp 0", pc);
    end
    tests++;
    if (fd_valid !== 1'b0 || fd_opcode !== 5'd0) begin
      fails++;
      $display("FAIL reset_valid got v=%b op=%h exp 0/0", fd_valid, fd_opcode);
    end
    tests++;
    if (imem_addr !== 12'd0 || stall_count !== 4'd0) begin
      fails++;
      $display("FAIL reset_addr_cnt got %h/%h exp 0/0", imem_addr, stall_count);
    end
  endtask

  task automatic test_freerun();
    cycle(0, 0, 0, 0);
    tests++;
    if (fd_insn !== 32'h1000_0000 || fd_pc_plus1 !== 32'd1 || pc !== 32'd1) begin
      fails++;
      $display("FAIL edge1 got insn=%h pp1=%h pc=%h exp 10000000/1/1",
               fd_insn, fd_pc_plus1, pc);
    end
    tests++;
    if (fd_valid !== 1'b1 || fd_opcode !== 5'h02) begin
      fails++;
      $display("FAIL edge1_op got v=%b op=%h exp 1/02", fd_valid, fd_opcode);
    end
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    tests++;
    if (fd_insn !== 32'h1000_0002 || pc !== 32'd3) begin
      fails++;
      $display("FAIL edge3 got insn=%h pc=%h exp 10000002/3", fd_insn, pc);
    end
  endtask

  task automatic test_stall();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    tests++;
    if (pc !== 32'd5 || fd_insn !== 32'h1000_0004 || stall_count !== 4'd0) begin
      fails++;
      $display("FAIL prestall got pc=%h insn=%h cnt=%h exp 5/10000004/0",
               pc, fd_insn, stall_count);
    end
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 1, 0, 0);
      tests++;
      if (pc !== 32'd5 || fd_insn !== 32'h1000_0004 ||
          stall_count !== 4'(i) || imem_addr !== 12'd5) begin
        fails++;
        $display("FAIL stall%0d got pc=%h insn=%h cnt=%h exp 5/10000004/%0d",
                 i, pc, fd_insn, stall_count, i);
      end
    end
    cycle(0, 0, 0, 0);
    tests++;
    if (fd_insn !== 32'h1000_0005 || pc !== 32'd6) begin
      fails++;
      $display("FAIL release got insn=%h pc=%h exp 10000005/6", fd_insn, pc);
    end
  endtask

  task automatic test_redirect();
    cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 32'h40);
    tests++;
    if (pc !== 32'h40 || fd_valid !== 1'b0 || fd_insn !== 32'd0 ||
        fd_opcode !== 5'd0 || stall_count !== 4'd3) begin
      fails++;
      $display("FAIL redir got pc=%h v=%b insn=%h op=%h cnt=%h exp 40/0/0/0/3",
               pc, fd_valid, fd_insn, fd_opcode, stall_count);
    end
    tests++;
    if (imem_addr !== 12'h040) begin
      fails++; $display("FAIL redir_addr got %h exp 040", imem_addr);
    end
    cycle(0, 0, 0, 0);
    tests++;
    if (fd_insn !== 32'h1000_0040 || fd_pc_plus1 !== 32'h41 ||
        fd_valid !== 1'b1) begin
      fails++;
      $display("FAIL redir_tgt got insn=%h pp1=%h v=%b exp 10000040/41/1",
               fd_insn, fd_pc_plus1, fd_valid);
    end
  endtask

  task automatic test_wrap();
    cycle(0, 0, 1, 32'hFFFF_FFFF);
    tests++;
    if (imem_addr !== 12'hFFF) begin
      fails++; $display("FAIL wrap_addr got %h exp fff", imem_addr);
    end
    cycle(0, 0, 0, 0);
    tests++;
    if (fd_pc_plus1 !== 32'd0 || pc !== 32'd0 || fd_insn !== 32'h1000_0FFF) begin
      fails++;
      $display("FAIL wrap got pp1=%h pc=%h insn=%h exp 0/0/10000fff",
               fd_pc_plus1, pc, fd_insn);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] holdPc;
    holdPc = pc;
    for (int i = 1; i <= 20; i++) begin
      cycle(0, 1, 0, 0);
      tests++;
      if (stall_count !== 4'((3 + i > 15) ? 15 : 3 + i) || pc !== holdPc) begin
        fails++;
        $display("FAIL sat%0d got cnt=%h pc=%h exp %0d/%h",
                 i, stall_count, pc, (3 + i > 15) ? 15 : 3 + i, holdPc);
      end
    end
  endtask

  task automatic test_reset_in_stall();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
    tests++;
    if (pc !== 32'd9 || stall_count !== 4'd4) begin
      fails++;
      $display("FAIL rst_pre got pc=%h cnt=%h exp 9/4", pc, stall_count);
    end
    cycle(1, 1, 0, 0);
    tests++;
    if (pc !== 32'd0 || stall_count !== 4'd0 || fd_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_stall got pc=%h cnt=%h v=%b exp 0/0/0",
               pc, stall_count, fd_valid);
    end
    cycle(0, 1, 0, 0);
    tests++;
    if (pc !== 32'd0 || fd_valid !== 1'b0 || stall_count !== 4'd1) begin
      fails++;
      $display("FAIL rst_hold got pc=%h v=%b cnt=%h exp 0/0/1",
               pc, fd_valid, stall_count);
    end
  endtask

  task automatic test_random();
    bit r, s, d;
    logic [31:0] t;
    logic [4:0]  expOp;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 49) == 0);
      d = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                      : $urandom;
      cycle(r, s, d, t);
      expOp = mValid ? mInsn[31:27] : 5'd0;
      tests++;
      if (pc !== mPc || imem_addr !== mPc[AW-1:0]) begin
        fails++;
        $display("FAIL rnd_pc n=%0d got %h/%h exp %h", n, pc, imem_addr, mPc);
      end
      tests++;
      if (fd_insn !== mInsn || fd_pc_plus1 !== mPp1 || fd_valid !== mValid ||
          fd_opcode !== expOp) begin
        fails++;
        $display("FAIL rnd_fd n=%0d got %h/%h/%b/%h exp %h/%h/%b/%h", n,
                 fd_insn, fd_pc_plus1, fd_valid, fd_opcode,
                 mInsn, mPp1, mValid, expOp);
      end
      tests++;
      if (stall_count !== 4'(mCnt)) begin
        fails++;
        $display("FAIL rnd_cnt n=%0d got %h exp %0d", n, stall_count, mCnt);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_freerun();
    test_stall();
    test_redirect();
    test_wrap();
    test_saturate();
    test_reset_in_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
